// File: rtl/rv_types.sv
// ============================================================================
//  Module      : rv_types (package)
//  Description : Shared types for the rv_core memory subsystem. Holds the
//                arbiter state encoding and the read-return owner record.
//  Contents    : arb_state_t - arbiter FSM state (S_RUN, S_INSN)
//                rsrc_t      - owner of the memory beat returning next cycle
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_types;

    // S_RUN : normal pass-through / data beat of a conflict
    // S_INSN: deferred fetch beat of a conflict
    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_INSN = 1'b1
    } arb_state_t;

    // Which port(s) consume m_dr on the following cycle.
    typedef struct packed {
        logic i;
        logic d;
    } rsrc_t;

endpackage

`default_nettype wire

// File: rtl/rv_mem_arb.sv
// ============================================================================
//  Module      : rv_mem_arb
//  Description : Merges the rv_core fetch port (i_*) and data port (d_*) onto
//                one shared synchronous memory port (m_*). A cycle where both
//                ports request is serialised: data beat first, then the fetch
//                beat, with the core stalled by i_rdy/d_rdy low. Conflict
//                stall cycles are counted in a saturating counter.
//  Ports       : clk, xreset (async, active-low)
//                i_adr/i_re -> i_dr/i_rdy              fetch port
//                d_adr/d_re/d_we/d_dw -> d_dr/d_rdy    data port
//                m_adr/m_re/m_we/m_dw <- m_dr/m_rdy    shared memory port
//                stall_cnt                             conflict stall cycles
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_mem_arb
    import rv_types::*;
#(
    parameter int AW   = 32,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            xreset,
    // fetch port
    input  logic [AW-1:0]   i_adr,
    input  logic            i_re,
    output logic [31:0]     i_dr,
    output logic            i_rdy,
    // data port
    input  logic [AW-1:0]   d_adr,
    input  logic            d_re,
    input  logic [3:0]      d_we,
    input  logic [31:0]     d_dw,
    output logic [31:0]     d_dr,
    output logic            d_rdy,
    // shared memory port
    output logic [AW-1:0]   m_adr,
    output logic            m_re,
    output logic [3:0]      m_we,
    output logic [31:0]     m_dw,
    input  logic [31:0]     m_dr,
    input  logic            m_rdy,
    // performance counter
    output logic [CNTW-1:0] stall_cnt
);

    localparam logic [CNTW-1:0] c_cnt_one = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] c_cnt_max = {CNTW{1'b1}};

    arb_state_t       r_state;
    arb_state_t       w_state_n;
    rsrc_t            r_rsrc;
    rsrc_t            w_rsrc_n;
    logic [31:0]      r_d_hold;
    logic             r_dh_v;
    logic             r_cap;        // first cycle of S_INSN: data beat is on m_dr
    logic [CNTW-1:0]  r_stall_cnt;

    logic             w_dreq;
    logic             w_d_rd;       // data read that actually reaches memory
    logic             w_rdy;
    logic             w_stall;
    logic             w_conf_acc;   // conflict data beat accepted this cycle

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            r_state     <= S_RUN;
            r_rsrc      <= '0;
            r_d_hold    <= '0;
            r_dh_v      <= 1'b0;
            r_cap       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_n;
            r_rsrc  <= w_rsrc_n;
            r_cap   <= w_conf_acc;

            // A new conflict read takes priority over clearing a consumed hold.
            if (w_conf_acc) begin
                r_dh_v <= w_d_rd;
            end else if (r_rsrc.d && r_dh_v) begin
                r_dh_v <= 1'b0;
            end

            // Only the first S_INSN cycle carries the data beat; later
            // wait-state cycles see unrelated m_dr and must not overwrite it.
            if (r_cap && r_dh_v) begin
                r_d_hold <= m_dr;
            end

            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and memory-port steering
    // ------------------------------------------------------------------
    always_comb begin
        w_dreq     = d_re | (d_we != 4'b0000);
        w_d_rd     = d_re & (d_we == 4'b0000);   // a write wins over a read
        w_state_n  = r_state;
        w_rsrc_n   = '0;
        w_rdy      = 1'b1;
        w_stall    = 1'b0;
        w_conf_acc = 1'b0;
        m_adr      = i_adr;
        m_re       = 1'b0;
        m_we       = 4'b0000;
        m_dw       = d_dw;

        case (r_state)
            S_RUN: begin
                if (w_dreq) begin
                    m_adr = d_adr;
                    m_re  = w_d_rd;
                    m_we  = d_we;
                    if (i_re) begin
                        w_rdy   = 1'b0;
                        w_stall = 1'b1;
                        if (m_rdy) begin
                            w_state_n  = S_INSN;
                            w_conf_acc = 1'b1;
                        end
                    end else begin
                        w_rdy      = m_rdy;
                        w_rsrc_n.d = m_rdy & w_d_rd;
                    end
                end else if (i_re) begin
                    m_re       = 1'b1;
                    w_rdy      = m_rdy;
                    w_rsrc_n.i = m_rdy;
                end
            end
            S_INSN: begin
                // Write enables stay low: the data write already completed.
                m_re  = 1'b1;
                w_rdy = m_rdy;
                if (m_rdy) begin
                    w_rsrc_n.i = 1'b1;
                    w_rsrc_n.d = r_dh_v;
                    w_state_n  = S_RUN;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: begin
                w_state_n = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // One shared ready gives the core a single global stall.
    assign i_rdy     = w_rdy;
    assign d_rdy     = w_rdy;
    assign i_dr      = r_rsrc.i ? m_dr : 32'h0;
    assign d_dr      = r_rsrc.d ? (r_dh_v ? r_d_hold : m_dr) : 32'h0;
    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rv_mem_arb.sv
// ============================================================================
//  Module      : tb_rv_mem_arb
//  Description : Self-checking bench for rv_mem_arb. A transaction-level
//                model (memory array + owed-fetch bookkeeping) predicts every
//                output each cycle; directed scenarios pin literal values.
//                A second instance with CNTW=4 sits in a permanent conflict
//                to exercise counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_mem_arb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        xreset;
    logic [31:0] i_adr, d_adr, d_dw, m_dr;
    logic        i_re, d_re, m_rdy;
    logic [3:0]  d_we;
    logic [31:0] i_dr, d_dr, m_adr, m_dw, stall_cnt;
    logic        i_rdy, d_rdy, m_re;
    logic [3:0]  m_we;

    logic [31:0] s_i_dr, s_d_dr, s_m_adr, s_m_dw;
    logic        s_i_rdy, s_d_rdy, s_m_re;
    logic [3:0]  s_m_we;
    logic [3:0]  s_stall;

    rv_mem_arb #(.AW(32), .CNTW(32)) u_dut (
        .clk(clk), .xreset(xreset),
        .i_adr(i_adr), .i_re(i_re), .i_dr(i_dr), .i_rdy(i_rdy),
        .d_adr(d_adr), .d_re(d_re), .d_we(d_we), .d_dw(d_dw), .d_dr(d_dr), .d_rdy(d_rdy),
        .m_adr(m_adr), .m_re(m_re), .m_we(m_we), .m_dw(m_dw), .m_dr(m_dr), .m_rdy(m_rdy),
        .stall_cnt(stall_cnt)
    );

    // Permanent conflict with a memory that never accepts.
    rv_mem_arb #(.AW(32), .CNTW(4)) u_sat (
        .clk(clk), .xreset(xreset),
        .i_adr(32'h0000_0100), .i_re(1'b1), .i_dr(s_i_dr), .i_rdy(s_i_rdy),
        .d_adr(32'h0000_2000), .d_re(1'b1), .d_we(4'b0000), .d_dw(32'h0), .d_dr(s_d_dr), .d_rdy(s_d_rdy),
        .m_adr(s_m_adr), .m_re(s_m_re), .m_we(s_m_we), .m_dw(s_m_dw), .m_dr(32'h0), .m_rdy(1'b0),
        .stall_cnt(s_stall)
    );

    int          vecs = 0;
    int          miss = 0;

    logic [31:0] mem [int unsigned];
    logic [31:0] nxt_dr;

    // model state
    bit          owed;       // data beat of a conflict done, fetch still owed
    bit          hv;         // conflict data read value pending delivery
    logic [31:0] hval;
    logic [31:0] ret_i, ret_d;
    longint      mstall;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (mem.exists(k)) return mem[k];
        return 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called once per cycle at the falling edge: checks outputs against the
    // model, advances the model, then plays the memory side of the cycle.
    task automatic model_step();
        logic        dreq, drd, e_re, e_rdy, chk_a;
        logic [3:0]  e_we;
        logic [31:0] e_adr, n_i, n_d, w;
        if (!xreset) begin
            owed = 0; hv = 0; hval = 0; ret_i = 0; ret_d = 0; mstall = 0;
            nxt_dr = $urandom;
            return;
        end
        chk("i_dr", i_dr, ret_i);
        chk("d_dr", d_dr, ret_d);
        chk("stall_cnt", stall_cnt, 32'(mstall));

        dreq  = d_re || (d_we != 4'b0000);
        drd   = d_re && (d_we == 4'b0000);
        n_i   = 0; n_d = 0;
        e_adr = i_adr; e_re = 0; e_we = 0; e_rdy = 1; chk_a = 0;
        if (owed) begin
            chk_a = 1; e_re = 1; e_rdy = m_rdy;
            if (m_rdy) begin
                n_i  = mem_rd(i_adr);
                n_d  = hv ? hval : 32'h0;
                owed = 0; hv = 0;
            end else mstall++;
        end else if (dreq) begin
            chk_a = 1; e_adr = d_adr; e_re = drd; e_we = d_we;
            if (i_re) begin
                e_rdy = 0; mstall++;
                if (m_rdy) begin
                    owed = 1; hv = drd; hval = mem_rd(d_adr);
                end
            end else begin
                e_rdy = m_rdy;
                if (m_rdy && drd) n_d = mem_rd(d_adr);
            end
        end else if (i_re) begin
            chk_a = 1; e_re = 1; e_rdy = m_rdy;
            if (m_rdy) n_i = mem_rd(i_adr);
        end
        if (mstall > 64'hFFFF_FFFF) mstall = 64'hFFFF_FFFF;

        chk("i_rdy", 32'(i_rdy), 32'(e_rdy));
        chk("d_rdy", 32'(d_rdy), 32'(e_rdy));
        chk("m_re",  32'(m_re),  32'(e_re));
        chk("m_we",  32'(m_we),  32'(e_we));
        if (chk_a)          chk("m_adr", m_adr, e_adr);
        if (e_we != 4'b0)   chk("m_dw",  m_dw,  d_dw);
        ret_i = n_i;
        ret_d = n_d;

        // memory: byte-masked write, registered read, garbage when idle
        if (m_rdy && (m_we != 4'b0)) begin
            w = mem_rd(m_adr);
            for (int b = 0; b < 4; b++) if (m_we[b]) w[8*b +: 8] = m_dw[8*b +: 8];
            mem[m_adr >> 2] = w;
        end
        nxt_dr = (m_rdy && m_re) ? mem_rd(m_adr) : $urandom;
    endtask

    task automatic drv();
        @(posedge clk);
        #1;
        m_dr = nxt_dr;
    endtask

    task automatic smp();
        @(negedge clk);
        model_step();
    endtask

    logic [4:0] wpat_rdy;
    logic [4:0] wpat_exp;
    int         we_cycles;
    bit         rdy_prev;
    int         kind;

    initial begin
        xreset = 0; i_adr = 0; d_adr = 0; d_dw = 0; m_dr = 0;
        i_re = 0; d_re = 0; d_we = 0; m_rdy = 1; nxt_dr = 0;
        owed = 0; hv = 0; hval = 0; ret_i = 0; ret_d = 0; mstall = 0;
        mem[32'h100 >> 2]  = 32'h0000_0013;
        mem[32'h104 >> 2]  = 32'h00A0_0093;
        mem[32'h2000 >> 2] = 32'hDEAD_BEEF;
        mem[32'h2004 >> 2] = 32'hFFFF_FFFF;

        // reset state
        smp(); smp();
        chk("rst_stall", stall_cnt, 32'h0);
        chk("rst_i_dr", i_dr, 32'h0);
        chk("rst_d_dr", d_dr, 32'h0);
        chk("rst_m_we", 32'(m_we), 32'h0);
        chk("rst_i_rdy", 32'(i_rdy), 32'h1);
        chk("rst_sat", 32'(s_stall), 32'h0);

        // fetch only
        drv(); xreset = 1; i_re = 1; i_adr = 32'h100; m_rdy = 1;
        smp(); chk("f1_rdy", 32'(i_rdy), 32'h1); chk("f1_adr", m_adr, 32'h100);
        drv(); i_re = 0;
        smp(); chk("f1_dr", i_dr, 32'h0000_0013); chk("f1_stall", stall_cnt, 32'h0);

        // load/fetch conflict
        drv(); i_adr = 32'h104; i_re = 1; d_re = 1; d_adr = 32'h2000; m_rdy = 1;
        smp(); chk("lc0_adr", m_adr, 32'h2000); chk("lc0_rdy", 32'(i_rdy), 32'h0);
        drv();
        smp(); chk("lc1_adr", m_adr, 32'h104); chk("lc1_rdy", 32'(d_rdy), 32'h1);
        drv(); i_re = 0; d_re = 0;
        smp(); chk("lc2_d_dr", d_dr, 32'hDEAD_BEEF); chk("lc2_i_dr", i_dr, 32'h00A0_0093);
        chk("lc2_stall", stall_cnt, 32'h1);

        // store/fetch conflict
        we_cycles = 0;
        drv(); d_we = 4'b0011; d_dw = 32'h1234_ABCD; d_adr = 32'h2004; i_re = 1; i_adr = 32'h108;
        smp(); if (m_we != 4'b0) we_cycles++;
        drv();
        smp(); if (m_we != 4'b0) we_cycles++;
        chk("st1_rdy", 32'(i_rdy), 32'h1); chk("st1_adr", m_adr, 32'h108);
        drv(); d_we = 0; i_re = 0;
        smp(); chk("st_we_cycles", 32'(we_cycles), 32'h1);
        chk("st_mem", mem_rd(32'h2004), 32'hFFFF_ABCD); chk("st_stall", stall_cnt, 32'h2);

        // wait states: 2 on the data beat, 1 on the fetch beat
        wpat_rdy = 5'b10100;   // bit n = m_rdy in cycle n
        wpat_exp = 5'b10000;   // bit n = expected rdy in cycle n
        drv(); i_re = 1; i_adr = 32'h10C; d_re = 1; d_adr = 32'h2000;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) drv();
            m_rdy = wpat_rdy[c];
            smp(); chk("ws_rdy", 32'(i_rdy), 32'(wpat_exp[c]));
        end
        drv(); i_re = 0; d_re = 0; m_rdy = 1;
        smp(); chk("ws_d_dr", d_dr, 32'hDEAD_BEEF); chk("ws_stall", stall_cnt, 32'h6);

        // async reset in the middle of S_INSN
        drv(); i_re = 1; i_adr = 32'h104; d_re = 1; d_adr = 32'h2000; m_rdy = 1;
        smp();
        drv(); m_rdy = 0;
        smp();
        #2 xreset = 0;
        #1;
        chk("ar_stall", stall_cnt, 32'h0);
        chk("ar_m_we", 32'(m_we), 32'h0);
        chk("ar_m_adr", m_adr, 32'h2000);
        chk("ar_rdy", 32'(i_rdy), 32'h0);
        drv(); i_re = 0; d_re = 0; m_rdy = 1;
        smp();
        drv(); xreset = 1; i_re = 1; i_adr = 32'h100;
        smp(); chk("ar_f_rdy", 32'(i_rdy), 32'h1); chk("sat_k", 32'(s_stall), 32'h0);
        drv(); i_re = 0;
        smp(); chk("ar_f_dr", i_dr, 32'h0000_0013); chk("ar_f_stall", stall_cnt, 32'h0);
        chk("sat_k", 32'(s_stall), 32'h1);
        for (int k = 2; k <= 20; k++) begin
            drv();
            smp(); chk("sat_k", 32'(s_stall), (k > 15) ? 32'd15 : 32'(k));
        end

        // randomized traffic; requests change only after acceptance
        rdy_prev = 1;
        for (int n = 0; n < 3000; n++) begin
            drv();
            m_rdy = ($urandom_range(0, 3) != 0);
            if (rdy_prev) begin
                kind = int'($urandom_range(0, 3));
                i_re = (kind == 1) || (kind == 3);
                d_re = 0; d_we = 0;
                if (kind >= 2) begin
                    if ($urandom_range(0, 1) == 1) d_re = 1;
                    else d_we = 4'($urandom_range(1, 15));
                end
                i_adr = 32'h100 + 32'($urandom_range(0, 15)) * 4;
                d_adr = (($urandom_range(0, 1) == 1) ? 32'h100 : 32'h2000) + 32'($urandom_range(0, 15)) * 4;
                d_dw  = $urandom;
            end
            smp();
            rdy_prev = i_rdy;
        end
        chk("sat_end", 32'(s_stall), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv_mem_arb.md
Name: rv_mem_arb

Overview:
- Two-port to one-port memory arbiter for rv_core.
- Merges the core's instruction-fetch port (i_*) and data port (d_*) onto a single shared synchronous memory port (m_*).
- Serialises conflicting cycles: data first, then instruction. Stalls the core by holding i_rdy/d_rdy low while it does so.
- Counts conflict stall cycles for performance monitoring.

Parameters:
- AW, 32, address width of all ports.
- CNTW, 32, width of stall_cnt.

Ports:
- clk  input  1  clock.
- xreset  input  1  reset, asynchronous, active-low.
- i_adr  input  AW  fetch address (core holds it stable while i_rdy=0).
- i_re  input  1  fetch request.
- i_dr  output  32  fetch data, valid the cycle after the granting i_rdy.
- i_rdy  output  1  fetch accepted.
- d_adr  input  AW  data address (held while d_rdy=0).
- d_re  input  1  data read request.
- d_we  input  4  byte write enables.
- d_dw  input  32  write data.
- d_dr  output  32  data read result, valid the cycle after the granting d_rdy.
- d_rdy  output  1  data accepted.
- m_adr  output  AW  shared memory address.
- m_re  output  1  shared memory read.
- m_we  output  4  shared memory byte write enables.
- m_dw  output  32  shared memory write data.
- m_dr  input  32  shared memory read data, one cycle after acceptance.
- m_rdy  input  1  memory accepts the current request (wait-state control).
- stall_cnt  output  CNTW  count of conflict stall cycles.

Behaviour:
- Request definitions:
  - dreq = d_re | (d_we != 0).
  - ireq = i_re.
  - If d_re and d_we are both active, the write wins and m_re = 0.
- FSM states S_RUN and S_INSN, plus registers d_hold (32), dh_v, rsrc (2 bits: {i,d} owner of the beat returning next cycle).
- Reset (async, xreset=0):
  - state = S_RUN; d_hold = 0; dh_v = 0; rsrc = 0; stall_cnt = 0.
  - Combinational outputs then follow the S_RUN rules with i_dr = d_dr = 0.
- S_RUN, only one requester active:
  - The m_* signals mirror that requester's address, enables and write data.
  - i_rdy = d_rdy = m_rdy.
  - On m_rdy, rsrc is set to the requester if it was a read.
- S_RUN, neither requester active:
  - m_re = 0, m_we = 0, i_rdy = d_rdy = 1.
  - rsrc = 0 next cycle.
- S_RUN, both active (conflict):
  - The m_* signals carry the data request; i_rdy = d_rdy = 0; stall_cnt increments.
  - When m_rdy = 1: move to S_INSN, and set dh_v = d_re.
  - When m_rdy = 0: stay in S_RUN, continue presenting the data request, still counting.
- S_INSN:
  - The m_* signals carry the fetch; m_we = 0, so the held d_we is never replayed.
  - On the first S_INSN cycle, capture m_dr into d_hold if dh_v.
  - When m_rdy = 1: i_rdy = d_rdy = 1, rsrc = {1, dh_v}, return to S_RUN.
  - When m_rdy = 0: stay in S_INSN; i_rdy = d_rdy = 0; stall_cnt increments; do not recapture d_hold.
- Read data routing (uses the registered rsrc):
  - i_dr = rsrc.i ? m_dr : 0.
  - d_dr = rsrc.d ? (dh_v ? d_hold : m_dr) : 0.
  - dh_v clears on the cycle after it is consumed.
- i_rdy and d_rdy are always equal. The core ANDs them, and keeping them equal gives a single global stall.
- stall_cnt saturates at all-ones; it does not wrap.
- Latency:
  - No conflict: 0 added cycles.
  - Conflict: exactly 1 added cycle with zero-wait memory, plus any m_rdy wait states on each beat.
- Reset mid-conflict aborts silently: the core is also in reset, and no write is replayed.

Decomposition:
- rv_types package:
  - Add arb_state_t (S_RUN, S_INSN).
  - Add a 2-bit rsrc_t struct {logic i; logic d;}.
- No sub-module needed; FSM, hold register and counter live in one file.
- rv_mem_arb sits between rv_core and the memory, replacing direct wiring.

Test Plan:
- Fetch only: i_re=1, i_adr=0x100, m_rdy=1, mem[0x100]=0x00000013 -> i_rdy=1 the same cycle; i_dr=0x00000013 next cycle; stall_cnt=0.
- Load/fetch conflict: i_adr=0x104, d_re=1, d_adr=0x2000, mem[0x2000]=0xDEADBEEF -> cycle0 m_adr=0x2000, rdy=0; cycle1 m_adr=0x104, rdy=1; cycle2 d_dr=0xDEADBEEF with i_dr=mem[0x104]; stall_cnt=1.
- Store/fetch conflict: d_we=4'b0011, d_dw=0x1234ABCD, d_adr=0x2004 held for 2 cycles -> m_we nonzero in exactly one cycle; mem[0x2004][15:0]=0xABCD; fetch served in cycle1.
- Wait states: conflict with m_rdy=0 for 2 cycles on the data beat and 1 cycle on the fetch beat -> rdy first high at cycle 4 (0-based); stall_cnt=4; d_hold captured exactly once.
- Async reset: assert xreset=0 mid-S_INSN (no clk edge) -> state S_RUN, stall_cnt=0, m_we=0 immediately; after release, a single fetch behaves as in scenario 1.
- Saturation: CNTW=4, run 20 conflict cycles -> stall_cnt=4'hF and holds.
